id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-issue stage of the 5-stage MIPS core, sitting directly upstream of the ALU. Each cycle it captures the decoded instruction from ID, derives the 4-bit ALU control code, resolves EX/MEM and MEM/WB forwarding onto the ALU operands, and detects load-use hazards. It handles stall, flush and bubble insertion so the ALU always sees a consistent operand set.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/alu_ctrl.sv | 30 +++
 rtl/id_ex_stage.sv | 199 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU control codes, aluop encodings and funct constants
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0000;
    localparam logic [3:0] ALU_NOP = 4'b1111;  // ALU drives 0 for this code

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,  // lw / sw address
        ALUOP_SUB   = 2'b01,  // beq compare
        ALUOP_RTYPE = 2'b10,  // decode from funct
        ALUOP_RSVD  = 2'b11   // unsupported
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - combinational aluop/funct to 4-bit ALU control code with illegal flag
// Ports: aluop_i, funct_i in; alu_ct_o (ALU code), illegal_o (unsupported encoding) out.
module alu_ctrl
    import mips_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ct_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ct_o  = ALU_NOP;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: alu_ct_o = ALU_ADD;
            ALUOP_SUB: alu_ct_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: alu_ct_o = ALU_ADD;
                    FUNCT_SUB: alu_ct_o = ALU_SUB;
                    FUNCT_SLT: alu_ct_o = ALU_SLT;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and load-use detection
// Ports: clk, rst (sync active-low); stall/flush pipeline control; id_* decoded instruction;
// exmem_*/memwb_* later-stage writeback for forwarding; ex_* / alu_* registered EX outputs; hazard_stall.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] exmem_res,
    input  logic [DW-1:0] memwb_data,
    output logic          ex_valid,
    output logic [3:0]    alu_ct,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wr_reg,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          ex_illegal,
    output logic          hazard_stall
);

    logic          valid_q,    valid_d;
    logic [3:0]    alu_ct_q,   alu_ct_d;
    logic          illegal_q,  illegal_d;
    logic [RW-1:0] rs_q,       rs_d;
    logic [RW-1:0] rt_q,       rt_d;
    logic [RW-1:0] wr_reg_q,   wr_reg_d;
    logic [DW-1:0] rs_data_q,  rs_data_d;
    logic [DW-1:0] rt_data_q,  rt_data_d;
    logic [DW-1:0] imm_q,      imm_d;
    logic          alusrc_q,   alusrc_d;
    logic          regwrite_q, regwrite_d;
    logic          memread_q,  memread_d;
    logic          memwrite_q, memwrite_d;
    logic          memtoreg_q, memtoreg_d;

    logic [3:0]    dec_ct;
    logic          dec_illegal;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    alu_ctrl u_alu_ctrl (
        .aluop_i   (id_aluop),
        .funct_i   (id_funct),
        .alu_ct_o  (dec_ct),
        .illegal_o (dec_illegal)
    );

    // A load in EX cannot supply its data until MEM/WB, so a dependent ID instruction must wait.
    assign hazard_stall = valid_q & memread_q & (wr_reg_q != '0)
                        & ((wr_reg_q == id_rs) | (wr_reg_q == id_rt)) & id_valid;

    // Register $0 is hardwired, so a write targeting it never forwards.
    function automatic logic [DW-1:0] forward(
        input logic [RW-1:0] src,
        input logic [DW-1:0] reg_data,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_res,
        input logic          mw_we,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_data
    );
        if (em_we && (em_rd == src) && (src != '0)) begin
            return em_res;
        end else if (mw_we && (mw_rd == src) && (src != '0)) begin
            return mw_data;
        end
        return reg_data;
    endfunction

    assign fwd_rs = forward(rs_q, rs_data_q, exmem_regwrite, exmem_rd, exmem_res,
                            memwb_regwrite, memwb_rd, memwb_data);
    assign fwd_rt = forward(rt_q, rt_data_q, exmem_regwrite, exmem_rd, exmem_res,
                            memwb_regwrite, memwb_rd, memwb_data);

    always_comb begin
        valid_d    = valid_q;
        alu_ct_d   = alu_ct_q;
        illegal_d  = illegal_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wr_reg_d   = wr_reg_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        // Flush beats stall; stall beats the load-use bubble so EX holds while downstream is blocked.
        if (flush || (!stall && hazard_stall)) begin
            valid_d    = 1'b0;
            alu_ct_d   = ALU_NOP;
            illegal_d  = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            wr_reg_d   = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            alusrc_d   = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
        end else if (!stall) begin
            valid_d    = id_valid;
            alu_ct_d   = dec_ct;
            illegal_d  = dec_illegal;
            rs_d       = id_rs;
            rt_d       = id_rt;
            wr_reg_d   = id_regdst ? id_rd : id_rt;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            alusrc_d   = id_alusrc;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
            memtoreg_d = id_memtoreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            alu_ct_q   <= ALU_NOP;
            illegal_q  <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            wr_reg_q   <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            alu_ct_q   <= alu_ct_d;
            illegal_q  <= illegal_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wr_reg_q   <= wr_reg_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    assign ex_valid      = valid_q;
    assign alu_ct        = alu_ct_q;
    assign ex_illegal    = illegal_q;
    assign ex_wr_reg     = wr_reg_q;
    assign alu_src1      = fwd_rs;
    assign alu_src2      = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_regwrite   = valid_q & regwrite_q;
    assign ex_memread    = valid_q & memread_q;
    assign ex_memwrite   = valid_q & memwrite_q;
    assign ex_memtoreg   = valid_q & memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with directed steps and random traffic
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_res, memwb_data;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, hazard_stall;
    logic [3:0]  alu_ct;
    logic [31:0] alu_src1, alu_src2, ex_store_data;
    logic [4:0]  ex_wr_reg;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_res(exmem_res), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .alu_ct(alu_ct), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
    );

    // Abstract picture of the instruction sitting in EX.
    typedef struct {
        bit          v;
        logic [3:0]  ct;
        bit          ill;
        logic [4:0]  rs, rt, wr;
        logic [31:0] rsd, rtd, imm;
        bit          alusrc, rw, mr, mw, mtr;
    } ex_t;

    ex_t m;
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic ex_t bubble_instr();
        ex_t b;
        b.v = 0; b.ct = 4'b1111; b.ill = 0;
        b.rs = 0; b.rt = 0; b.wr = 0; b.rsd = 0; b.rtd = 0; b.imm = 0;
        b.alusrc = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.mtr = 0;
        return b;
    endfunction

    // Returns {illegal, alu code}.
    function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return {1'b0, 4'b0010};
        if (op == 2'd1) return {1'b0, 4'b0110};
        if (op == 2'd2) begin
            if (fn == 6'd32) return {1'b0, 4'b0010};
            if (fn == 6'd34) return {1'b0, 4'b0110};
            if (fn == 6'd42) return {1'b0, 4'b0000};
        end
        return {1'b1, 4'b1111};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] d);
        if (src == 0) return d;
        if (exmem_regwrite && exmem_rd == src) return exmem_res;
        if (memwb_regwrite && memwb_rd == src) return memwb_data;
        return d;
    endfunction

    function automatic bit model_hazard();
        return m.v && m.mr && (m.wr != 0) && ((m.wr == id_rs) || (m.wr == id_rt)) && id_valid;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_valid"},  32'(ex_valid), 32'(m.v));
        chk({tag, ".alu_ct"},    32'(alu_ct), 32'(m.ct));
        chk({tag, ".illegal"},   32'(ex_illegal), 32'(m.ill));
        chk({tag, ".src1"},      alu_src1, fwd(m.rs, m.rsd));
        chk({tag, ".src2"},      alu_src2, m.alusrc ? m.imm : fwd(m.rt, m.rtd));
        chk({tag, ".store"},     ex_store_data, fwd(m.rt, m.rtd));
        chk({tag, ".wr_reg"},    32'(ex_wr_reg), 32'(m.wr));
        chk({tag, ".regwrite"},  32'(ex_regwrite), 32'(m.v & m.rw));
        chk({tag, ".memread"},   32'(ex_memread), 32'(m.v & m.mr));
        chk({tag, ".memwrite"},  32'(ex_memwrite), 32'(m.v & m.mw));
        chk({tag, ".memtoreg"},  32'(ex_memtoreg), 32'(m.v & m.mtr));
        chk({tag, ".hazard"},    32'(hazard_stall), 32'(model_hazard()));
    endtask

    // Advance one clock edge and apply the pipeline priority rules to the model.
    task automatic tick();
        bit hz;
        hz = model_hazard();
        @(posedge clk);
        if (!rst || flush) m = bubble_instr();
        else if (stall) ;
        else if (hz) m = bubble_instr();
        else begin
            m.v = id_valid;
            {m.ill, m.ct} = decode(id_aluop, id_funct);
            m.rs = id_rs; m.rt = id_rt; m.wr = id_regdst ? id_rd : id_rt;
            m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
            m.alusrc = id_alusrc; m.rw = id_regwrite; m.mr = id_memread;
            m.mw = id_memwrite; m.mtr = id_memtoreg;
        end
        #1;
    endtask

    // Settle combinational paths, check everything, then clock.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic clear_id();
        id_valid = 0; id_aluop = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0; id_regdst = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_res = 0; memwb_data = 0; stall = 0; flush = 0;
    endtask

    initial begin
        m = bubble_instr();
        rst = 0;
        clear_id();
        // Reset with stall high and garbage on ID: stall must be ignored.
        stall = 1; id_valid = 1; id_aluop = 2; id_funct = 6'h20; id_rs = 4; id_rs_data = 32'hDEAD;
        tick();
        #1;
        check_all("reset");
        chk("reset.alu_ct_const", 32'(alu_ct), 32'hF);
        rst = 1;
        clear_id();

        // R-type add
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'h20; id_rs = 1; id_rt = 2; id_rd = 9;
        id_regdst = 1; id_regwrite = 1; id_rs_data = 5; id_rt_data = 7;
        cycle("radd_pre");
        #1;
        check_all("radd");
        chk("radd.ct_const", 32'(alu_ct), 32'h2);
        chk("radd.src1_const", alu_src1, 32'd5);
        chk("radd.src2_const", alu_src2, 32'd7);
        chk("radd.valid_const", 32'(ex_valid), 32'd1);

        // Immediate path
        clear_id();
        id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_rt = 6; id_rt_data = 32'h1234;
        tick();
        #1;
        check_all("imm");
        chk("imm.src2_const", alu_src2, 32'hFFFF_FFFC);
        chk("imm.ct_const", 32'(alu_ct), 32'h2);

        // Forwarding priority
        clear_id();
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'h22; id_rs = 3; id_rs_data = 32'h55;
        tick();
        exmem_regwrite = 1; exmem_rd = 3; exmem_res = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_data = 32'h22;
        #1;
        chk("fwd.exmem", alu_src1, 32'h11);
        check_all("fwd_exmem");
        exmem_regwrite = 0;
        #1;
        chk("fwd.memwb", alu_src1, 32'h22);
        check_all("fwd_memwb");
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        id_rs = 0; id_rs_data = 32'h99;
        tick();
        #1;
        chk("fwd.zero_reg", alu_src1, 32'h99);
        check_all("fwd_zero");

        // Load-use hazard
        clear_id();
        id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_memread = 1; id_regwrite = 1;
        id_memtoreg = 1; id_rt = 8; id_rs = 29; id_imm = 4;
        tick();
        clear_id();
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'h20; id_rs = 8; id_rt = 2;
        #1;
        chk("lu.hazard_const", 32'(hazard_stall), 32'd1);
        check_all("lu_detect");
        stall = 1;  // stall wins: EX holds and the hazard stays visible
        tick();
        #1;
        chk("lu_stall.hazard_const", 32'(hazard_stall), 32'd1);
        check_all("lu_stall");
        stall = 0;
        tick();
        #1;
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu.bubble_ct", 32'(alu_ct), 32'hF);
        check_all("lu_bubble");

        // Flush and stall together
        clear_id();
        id_valid = 1; id_aluop = 2'b00; id_memwrite = 1; id_rs = 4; id_rt = 5;
        tick();
        flush = 1; stall = 1;
        tick();
        #1;
        chk("fs.valid", 32'(ex_valid), 32'd0);
        chk("fs.ctrls", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 32'd0);
        check_all("flush_stall");

        // Illegal funct, then a single reset edge
        clear_id();
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'h24; id_rs = 1; id_rs_data = 3;
        tick();
        #1;
        chk("ill.ct", 32'(alu_ct), 32'hF);
        chk("ill.flag", 32'(ex_illegal), 32'd1);
        check_all("illegal");
        rst = 0; stall = 1;
        tick();
        rst = 1; stall = 0;
        #1;
        chk("rst2.illegal", 32'(ex_illegal), 32'd0);
        check_all("rst_mid");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] fsel;
            rst = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_aluop = 2'($urandom_range(0, 3));
            fsel = 2'($urandom_range(0, 3));
            id_funct = (fsel == 0) ? 6'h20 : (fsel == 1) ? 6'h22 : (fsel == 2) ? 6'h2A : 6'($urandom);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
            id_memread = 1'($urandom); id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
            exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
            exmem_res = $urandom; memwb_data = $urandom;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
